// File: rtl/ram_port_arb.sv
// ram_port_arb: round-robin arbiter with lock bursts sharing one block-RAM port among CReqCnt requesters.
module ram_port_arb #(
  parameter int CAddrLen = 11,
  parameter int CDataLen = 8,
  parameter int CReqCnt  = 4
) (
  input  logic                         AClk,
  input  logic                         AReset,
  input  logic                         AClkEn,
  input  logic [CReqCnt*CAddrLen-1:0]  AReqAddr,
  input  logic [CReqCnt*CDataLen-1:0]  AReqMosi,
  input  logic [CReqCnt-1:0]           AReqWrEn,
  input  logic [CReqCnt-1:0]           AReqRdEn,
  input  logic [CReqCnt-1:0]           AReqLock,
  output logic [CReqCnt-1:0]           AReqAck,
  output logic [CDataLen-1:0]          AReqMiso,
  output logic [CReqCnt-1:0]           AReqMisoVld,
  output logic [CAddrLen-1:0]          ARamAddr,
  output logic [CDataLen-1:0]          ARamMosi,
  output logic                         ARamWrEn,
  output logic                         ARamRdEn,
  input  logic [CDataLen-1:0]          ARamMiso
);
  localparam int CIdxLen = $clog2(CReqCnt);
  typedef logic [CIdxLen-1:0] idx_t;
  logic [CReqCnt-1:0] req;
  idx_t prio, own_idx, rd_idx, win;
  logic own_vld, rd_vld, any, grant;

  function automatic idx_t wrap(input int v);
    return idx_t'(v >= CReqCnt ? v - CReqCnt : v);
  endfunction

  assign req   = AReqWrEn | AReqRdEn;
  assign any   = |req;
  assign grant = AClkEn & any;

  // scan downwards so the requester closest to prio is the last (winning) assignment
  always_comb begin
    win = own_idx;
    if (!(own_vld && req[own_idx]))
      for (int k = CReqCnt - 1; k >= 0; k--)
        if (req[wrap(int'(prio) + k)]) win = wrap(int'(prio) + k);
  end

  assign AReqAck  = grant ? (CReqCnt'(1) << win) : '0;
  assign ARamAddr = grant ? AReqAddr[win*CAddrLen +: CAddrLen] : '0;
  assign ARamMosi = grant ? AReqMosi[win*CDataLen +: CDataLen] : '0;
  assign ARamWrEn = grant & AReqWrEn[win];
  // a combined write+read request is served as a write only
  assign ARamRdEn = grant & AReqRdEn[win] & ~AReqWrEn[win];
  assign AReqMisoVld = rd_vld ? (CReqCnt'(1) << rd_idx) : '0;
  assign AReqMiso    = rd_vld ? ARamMiso : '0;

  always_ff @(posedge AClk or posedge AReset)
    if (AReset) begin
      prio    <= '0;
      own_vld <= 1'b0;
      own_idx <= '0;
      rd_vld  <= 1'b0;
      rd_idx  <= '0;
    end else if (AClkEn) begin
      prio    <= any ? wrap(int'(win) + 1) : prio;
      own_vld <= any & AReqLock[win];
      own_idx <= any ? win : own_idx;
      rd_vld  <= ARamRdEn;
      rd_idx  <= win;
    end
endmodule

// File: tb/tb_ram_port_arb.sv
// tb_ram_port_arb: directed stimulus against a transaction-level arbiter/RAM model, checked every cycle.
module tb_ram_port_arb;
  localparam int N = 4, AW = 11, DW = 8;
  logic AClk = 0, AReset, AClkEn;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] mosi;
  logic [N-1:0] wr, rd, lock, ack, vld;
  logic [DW-1:0] miso, ram_mosi, ram_q;
  logic [AW-1:0] ram_addr;
  logic ram_wr, ram_rd;
  bit [DW-1:0] ram [2**AW];
  bit [DW-1:0] mmem [2**AW];
  int m_prio, m_own, m_rd, vcnt, n_chk, n_pass;
  bit [DW-1:0] m_rd_data;

  ram_port_arb dut (
    .AClk(AClk), .AReset(AReset), .AClkEn(AClkEn), .AReqAddr(addr), .AReqMosi(mosi),
    .AReqWrEn(wr), .AReqRdEn(rd), .AReqLock(lock), .AReqAck(ack), .AReqMiso(miso),
    .AReqMisoVld(vld), .ARamAddr(ram_addr), .ARamMosi(ram_mosi), .ARamWrEn(ram_wr),
    .ARamRdEn(ram_rd), .ARamMiso(ram_q)
  );

  always #5 AClk = ~AClk;

  always @(posedge AClk)
    if (AClkEn) begin
      if (ram_wr) ram[ram_addr] <= ram_mosi;
      ram_q <= ram_rd ? ram[ram_addr] : '0;
    end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
  endtask

  function automatic int exp_win();
    if (m_own >= 0 && (wr[m_own] || rd[m_own])) return m_own;
    for (int k = 0; k < N; k++)
      if (wr[(m_prio + k) % N] || rd[(m_prio + k) % N]) return (m_prio + k) % N;
    return -1;
  endfunction

  always @(posedge AClk or posedge AReset)
    if (AReset) begin
      m_prio = 0; m_own = -1; m_rd = -1;
    end else if (AClkEn) begin
      int w;
      w = exp_win();
      m_rd = -1;
      if (w < 0) m_own = -1;
      else begin
        if (wr[w]) mmem[int'(addr[w*AW +: AW])] = mosi[w*DW +: DW];
        else begin
          m_rd = w;
          m_rd_data = mmem[int'(addr[w*AW +: AW])];
        end
        m_prio = (w + 1) % N;
        m_own = lock[w] ? w : -1;
      end
    end

  always @(negedge AClk) begin
    int w;
    bit g;
    w = exp_win();
    g = AClkEn && w >= 0;
    chk("ack", 32'(ack), g ? (32'd1 << w) : 32'd0);
    chk("ram_wr", 32'(ram_wr), 32'(g && wr[w]));
    chk("ram_rd", 32'(ram_rd), 32'(g && rd[w] && !wr[w]));
    chk("ram_addr", 32'(ram_addr), g ? 32'(addr[w*AW +: AW]) : 32'd0);
    chk("ram_mosi", 32'(ram_mosi), g ? 32'(mosi[w*DW +: DW]) : 32'd0);
    chk("miso_vld", 32'(vld), m_rd >= 0 ? (32'd1 << m_rd) : 32'd0);
    chk("miso", 32'(miso), m_rd >= 0 ? 32'(m_rd_data) : 32'd0);
    if (AClkEn && vld[3]) vcnt++;
  end

  task automatic tick();
    @(posedge AClk); #1;
  endtask

  task automatic clr();
    wr = '0; rd = '0; lock = '0;
  endtask

  task automatic set_req(int i, bit w, bit r, bit l, logic [AW-1:0] a, logic [DW-1:0] d);
    wr[i] = w; rd[i] = r; lock[i] = l;
    addr[i*AW +: AW] = a;
    mosi[i*DW +: DW] = d;
  endtask

  initial begin
    #100000 $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] pa [5] = '{11'h155, 11'h000, 11'h010, 11'h020, 11'h030};
    logic [DW-1:0] pd [5] = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13};
    AReset = 1; AClkEn = 1; addr = '0; mosi = '0; clr();
    #2;
    chk("rst_vld", 32'(vld), 0);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_ack", 32'(ack), 0);
    #10 AReset = 0;
    // preload RAM through the port itself
    for (int k = 0; k < 5; k++) begin
      tick(); set_req(0, 1, 0, 0, pa[k], pd[k]);
    end
    tick(); clr();
    AReset = 1; #1 AReset = 0;
    // single read
    tick(); set_req(2, 0, 1, 0, 11'h155, 0); #1;
    chk("sr_ack", 32'(ack), 32'b0100);
    chk("sr_rden", 32'(ram_rd), 1);
    chk("sr_addr", 32'(ram_addr), 32'h155);
    tick(); clr(); #1;
    chk("sr_vld", 32'(vld), 32'b0100);
    chk("sr_miso", 32'(miso), 32'hA5);
    tick(); #1;
    chk("sr_vld_off", 32'(vld), 0);
    chk("sr_miso_off", 32'(miso), 0);
    // round robin from reset
    AReset = 1; #1 AReset = 0;
    for (int i = 0; i < N; i++) set_req(i, 0, 1, 0, AW'(i * 16), 0);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("rr_ack", 32'(ack), 32'd1 << (c % 4));
      if (c > 0) begin
        chk("rr_vld", 32'(vld), 32'd1 << ((c - 1) % 4));
        chk("rr_miso", 32'(miso), 32'h10 + 32'((c - 1) % 4));
      end
      tick(); #1;
    end
    clr();
    // lock burst
    AReset = 1; #1 AReset = 0;
    set_req(0, 1, 0, 0, 11'h020, 8'h11); #1;
    chk("lk_pre", 32'(ack), 32'b0001);
    tick(); clr();
    set_req(0, 0, 1, 0, 11'h030, 0);
    set_req(3, 0, 1, 0, 11'h031, 0);
    set_req(1, 1, 0, 1, 11'h040, 8'hB1); #1;
    chk("lk_a1", 32'(ack), 32'b0010);
    tick(); set_req(1, 1, 0, 1, 11'h041, 8'hB2); #1;
    chk("lk_a2", 32'(ack), 32'b0010);
    tick(); set_req(1, 1, 0, 0, 11'h042, 8'hB3); #1;
    chk("lk_a3", 32'(ack), 32'b0010);
    tick(); set_req(1, 0, 0, 0, 0, 0); #1;
    chk("lk_a4", 32'(ack), 32'b1000);
    tick(); set_req(3, 0, 0, 0, 0, 0); #1;
    chk("lk_a5", 32'(ack), 32'b0001);
    tick(); clr();
    // gap in a locked burst releases ownership
    set_req(1, 1, 0, 1, 11'h043, 8'hB4); #1;
    chk("gap_own", 32'(ack), 32'b0010);
    tick(); set_req(1, 0, 0, 0, 0, 0); set_req(2, 0, 1, 0, 11'h043, 0); #1;
    chk("gap_other", 32'(ack), 32'b0100);
    tick(); set_req(2, 0, 0, 0, 0, 0);
    set_req(1, 1, 0, 1, 11'h044, 8'hB5); set_req(3, 0, 1, 0, 11'h040, 0); #1;
    chk("gap_rr", 32'(ack), 32'b1000);
    chk("gap_vld", 32'(vld), 32'b0100);
    chk("gap_miso", 32'(miso), 32'hB4);
    tick(); set_req(3, 0, 0, 0, 0, 0); #1;
    chk("gap_back", 32'(ack), 32'b0010);
    chk("gap_miso2", 32'(miso), 32'hB1);
    tick(); clr();
    // write and read strobes together
    set_req(0, 1, 1, 0, 11'h007, 8'h3C); #1;
    chk("wr_rd_ack", 32'(ack), 32'b0001);
    chk("wr_rd_wren", 32'(ram_wr), 1);
    chk("wr_rd_rden", 32'(ram_rd), 0);
    tick(); clr(); #1;
    chk("wr_rd_novld", 32'(vld), 0);
    set_req(0, 0, 1, 0, 11'h007, 0); #1;
    chk("rb_ack", 32'(ack), 32'b0001);
    tick(); clr(); #1;
    chk("rb_vld", 32'(vld), 32'b0001);
    chk("rb_miso", 32'(miso), 32'h3C);
    // clock-enable stall
    set_req(3, 0, 1, 0, 11'h155, 0); vcnt = 0; #1;
    chk("ce_ack", 32'(ack), 32'b1000);
    tick(); clr(); AClkEn = 0; set_req(0, 0, 1, 0, 11'h005, 0);
    repeat (3) begin
      #1;
      chk("ce_noack", 32'(ack), 0);
      chk("ce_rd", 32'(ram_rd), 0);
      chk("ce_wr", 32'(ram_wr), 0);
      chk("ce_vld", 32'(vld), 32'b1000);
      chk("ce_miso", 32'(miso), 32'hA5);
      tick();
    end
    AClkEn = 1; clr(); #1;
    chk("ce_vld_en", 32'(vld), 32'b1000);
    tick(); #1;
    chk("ce_vld_off", 32'(vld), 0);
    chk("ce_events", 32'(vcnt), 1);
    // reset while a read is returning
    set_req(2, 0, 1, 0, 11'h155, 0); #1;
    chk("rm_ack", 32'(ack), 32'b0100);
    tick(); clr(); #1;
    chk("rm_vld_pre", 32'(vld), 32'b0100);
    AReset = 1; #1;
    chk("rm_vld", 32'(vld), 0);
    chk("rm_miso", 32'(miso), 0);
    tick(); #1 AReset = 0;
    set_req(0, 0, 1, 0, 11'h001, 0); set_req(3, 0, 1, 0, 11'h002, 0); #1;
    chk("rm_first", 32'(ack), 32'b0001);
    tick(); clr();
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
